// File: rtl/adsr_voice_seq.sv
// adsr_voice_seq: per-voice ADSR state store with a round-robin scan.
// Each accepted tick walks every voice once. The voice's stored state is
// presented to an external update stage, and the result is written back.
// The written-back volume is also reported on the vol_* strobe.
// Optional feature: define ADSR_SEQ_OVERRUN_EN to add overrun_cnt, which
// counts ticks that arrive while a scan is still running.

// One voice slot: state, volume and the two pending-event flags.
module adsr_voice_cell (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_en,
    input  logic [2:0]  new_state,
    input  logic [17:0] new_volume,
    input  logic        ev_en,
    input  logic        ev_on,
    output logic [2:0]  state,
    output logic [17:0] volume,
    output logic        pend_press,
    output logic        pend_rel
);
    // Writeback clears the flags first, and a same-cycle event then overrides
    // them. This keeps an event that lands during this voice's writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= 3'd0;
            volume     <= 18'd0;
            pend_press <= 1'b0;
            pend_rel   <= 1'b0;
        end else begin
            if (wb_en) begin
                state      <= new_state;
                volume     <= new_volume;
                pend_press <= 1'b0;
                pend_rel   <= 1'b0;
            end
            if (ev_en) begin
                pend_press <= ev_on;
                pend_rel   <= ~ev_on;
            end
        end
    end
endmodule

module adsr_voice_seq #(
    parameter int NUM_VOICES = 16,
    parameter int VW         = $clog2(NUM_VOICES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          ev_valid,
    output logic          ev_ready,
    input  logic [VW-1:0] ev_voice,
    input  logic          ev_on,
    output logic [2:0]    adsr_state,
    output logic [17:0]   adsr_volume,
    output logic          adsr_pressed,
    output logic          adsr_released,
    input  logic [2:0]    adsr_new_state,
    input  logic [17:0]   adsr_new_volume,
    output logic          busy,
    output logic          vol_valid,
    output logic [VW-1:0] vol_voice,
`ifdef ADSR_SEQ_OVERRUN_EN
    output logic [7:0]    overrun_cnt,
`endif
    output logic [17:0]   vol_value
);
    localparam logic [5:0] LAST = 6'(NUM_VOICES - 1);

    typedef enum logic {IDLE, SCAN} scan_t;

    scan_t      state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic       scan;
    logic       rdy_q;
    logic       ev_acc;
    logic [VW-1:0] sel;

    logic [NUM_VOICES-1:0][2:0]  v_state;
    logic [NUM_VOICES-1:0][17:0] v_vol;
    logic [NUM_VOICES-1:0]       v_press;
    logic [NUM_VOICES-1:0]       v_rel;

    assign scan     = (state_q == SCAN);
    assign busy     = scan;
    // Ready stays low through reset and for one cycle after it.
    assign ev_ready = rst_n & rdy_q;
    assign ev_acc   = ev_valid & ev_ready;

    // In IDLE the read port parks on voice 0.
    assign sel           = scan ? idx_q[VW-1:0] : '0;
    assign adsr_state    = v_state[sel];
    assign adsr_volume   = v_vol[sel];
    assign adsr_pressed  = v_press[sel];
    assign adsr_released = v_rel[sel];

    genvar g;
    generate
        for (g = 0; g < NUM_VOICES; g++) begin : g_voice
            adsr_voice_cell u_cell (
                .clk        (clk),
                .rst_n      (rst_n),
                .wb_en      (scan && (idx_q == 6'(g))),
                .new_state  (adsr_new_state),
                .new_volume (adsr_new_volume),
                .ev_en      (ev_acc && (ev_voice == VW'(g))),
                .ev_on      (ev_on),
                .state      (v_state[g]),
                .volume     (v_vol[g]),
                .pend_press (v_press[g]),
                .pend_rel   (v_rel[g])
            );
        end
    endgenerate

    // Scan FSM state and index register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: a tick starts a scan only from IDLE; the scan ends after the last voice.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = 6'd0;
                end
            end
            SCAN: begin
                if (idx_q == LAST) begin
                    state_d = IDLE;
                    idx_d   = 6'd0;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 6'd0;
            end
        endcase
    end

    // Ready goes high one cycle after reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    // Report each writeback one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vol_valid <= 1'b0;
            vol_voice <= '0;
            vol_value <= 18'd0;
        end else begin
            vol_valid <= scan;
            if (scan) begin
                vol_voice <= idx_q[VW-1:0];
                vol_value <= adsr_new_volume;
            end
        end
    end

`ifdef ADSR_SEQ_OVERRUN_EN
    // Count ticks dropped because a scan was running; saturates at 255.
    always_ff @(posedge clk) begin
        if (!rst_n)                              overrun_cnt <= 8'd0;
        else if (tick && scan && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
    end
`endif

endmodule
